// File: rtl/cr_cddip_sa_snap_ctrl.sv
// Statistics snapshot/clear sequencer: walks N_ENTRIES indices issuing snap then clear strobes.
// Latency: strobes start the cycle after the request edge is sampled; DONE follows the last walk.
// No backpressure: requests arriving while busy collapse into one pending flag per type. Optional auto timer: CR_CDDIP_SA_AUTO_SNAP_EN.
module cr_cddip_sa_snap_ctrl #(
    parameter int unsigned N_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regs_sa_snap,
    input  logic        regs_sa_clear_live,
    input  logic [31:0] cfg_period,
    input  logic        cfg_period_en,
    output logic        sa_snap_stb,
    output logic        sa_clear_stb,
    output logic [5:0]  sa_idx,
    output logic        snap_busy,
    output logic        snap_done,
    output logic [15:0] snap_count
);

    localparam logic [5:0] IDX_LAST = 6'(N_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        snap_prev, clr_prev;
    logic        snap_edge, clr_req, auto_req, snap_req;
    logic        pend_snap, pend_snap_nxt;
    logic        pend_clr, pend_clr_nxt;
    logic        do_clear, do_clear_nxt;
    logic        did_snap, did_snap_nxt;
    logic [5:0]  idx_nxt;
    logic        snap_stb_nxt, clear_stb_nxt, busy_nxt, done_nxt;
    logic [15:0] count_nxt;
    logic [15:0] count_inc;

    assign snap_edge = regs_sa_snap & ~snap_prev;
    assign clr_req   = regs_sa_clear_live & ~clr_prev;
    assign snap_req  = snap_edge | auto_req;
    assign count_inc = (did_snap && snap_count != 16'hFFFF) ? snap_count + 16'd1 : snap_count;

`ifdef CR_CDDIP_SA_AUTO_SNAP_EN
    logic [31:0] timer;
    logic        timer_run;

    assign timer_run = cfg_period_en && (cfg_period != 32'd0);
    // >= so a period lowered below the current count still wraps promptly
    assign auto_req  = timer_run && (timer >= cfg_period - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= 32'd0;
        end else if (!timer_run || auto_req) begin
            timer <= 32'd0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_period, cfg_period_en};
    assign auto_req   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            snap_prev    <= 1'b0;
            clr_prev     <= 1'b0;
            pend_snap    <= 1'b0;
            pend_clr     <= 1'b0;
            do_clear     <= 1'b0;
            did_snap     <= 1'b0;
            sa_idx       <= 6'd0;
            sa_snap_stb  <= 1'b0;
            sa_clear_stb <= 1'b0;
            snap_busy    <= 1'b0;
            snap_done    <= 1'b0;
            snap_count   <= 16'd0;
        end else begin
            state        <= state_nxt;
            snap_prev    <= regs_sa_snap;
            clr_prev     <= regs_sa_clear_live;
            pend_snap    <= pend_snap_nxt;
            pend_clr     <= pend_clr_nxt;
            do_clear     <= do_clear_nxt;
            did_snap     <= did_snap_nxt;
            sa_idx       <= idx_nxt;
            sa_snap_stb  <= snap_stb_nxt;
            sa_clear_stb <= clear_stb_nxt;
            snap_busy    <= busy_nxt;
            snap_done    <= done_nxt;
            snap_count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_snap_nxt = pend_snap;
        pend_clr_nxt  = pend_clr;
        do_clear_nxt  = do_clear;
        did_snap_nxt  = did_snap;
        idx_nxt       = 6'd0;
        snap_stb_nxt  = 1'b0;
        clear_stb_nxt = 1'b0;
        busy_nxt      = 1'b1;
        done_nxt      = 1'b0;
        count_nxt     = snap_count;

        if (state != IDLE) begin
            pend_snap_nxt = pend_snap | snap_req;
            pend_clr_nxt  = pend_clr | clr_req;
        end

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (snap_req || pend_snap) begin
                    // a clear folds into the snap walk only when software asked for both
                    state_nxt     = SNAP;
                    snap_stb_nxt  = 1'b1;
                    busy_nxt      = 1'b1;
                    did_snap_nxt  = 1'b1;
                    do_clear_nxt  = clr_req | pend_clr | (snap_edge & regs_sa_clear_live);
                    pend_snap_nxt = 1'b0;
                    if (do_clear_nxt) begin
                        pend_clr_nxt = 1'b0;
                    end
                end else if (clr_req || pend_clr) begin
                    state_nxt     = CLEAR;
                    clear_stb_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    did_snap_nxt  = 1'b0;
                    do_clear_nxt  = 1'b0;
                    pend_clr_nxt  = 1'b0;
                end
            end
            SNAP: begin
                if (sa_idx == IDX_LAST) begin
                    if (do_clear) begin
                        state_nxt     = CLEAR;
                        clear_stb_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        count_nxt = count_inc;
                    end
                end else begin
                    idx_nxt      = sa_idx + 6'd1;
                    snap_stb_nxt = 1'b1;
                end
            end
            CLEAR: begin
                if (sa_idx == IDX_LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    count_nxt = count_inc;
                end else begin
                    idx_nxt       = sa_idx + 6'd1;
                    clear_stb_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cr_cddip_sa_snap_ctrl.sv
// Bench for cr_cddip_sa_snap_ctrl: a walk-schedule model predicts every output each cycle,
// and directed literal checks pin the model at the key cycles.
module tb_cr_cddip_sa_snap_ctrl;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        regs_sa_snap = 1'b0;
    logic        regs_sa_clear_live = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic        cfg_period_en = 1'b0;
    logic        sa_snap_stb, sa_clear_stb, snap_busy, snap_done;
    logic [5:0]  sa_idx;
    logic [15:0] snap_count;

    cr_cddip_sa_snap_ctrl #(.N_ENTRIES(N)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .regs_sa_snap       (regs_sa_snap),
        .regs_sa_clear_live (regs_sa_clear_live),
        .cfg_period         (cfg_period),
        .cfg_period_en      (cfg_period_en),
        .sa_snap_stb        (sa_snap_stb),
        .sa_clear_stb       (sa_clear_stb),
        .sa_idx             (sa_idx),
        .snap_busy          (snap_busy),
        .snap_done          (snap_done),
        .snap_count         (snap_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: a walk is a start edge plus which phases it contains; outputs follow by arithmetic.
    int          cyc = 0;
    bit          m_prev_s = 0, m_prev_c = 0, m_ps = 0, m_pc = 0;
    bit          w_v = 0, w_s = 0, w_c = 0;
    int          w_k = 0;
    int          free_at = 0;
    int          m_walks = 0;
    logic [31:0] m_tmr = 32'd0;
    int          cnt_ofs = 0;
    int          walk_mark = 0;

    always @(posedge clk) begin : model
        bit se, ce, ae, ws, wc, start;
        int e;
        e = cyc + 1;
        cyc <= e;
        se = 0; ce = 0; ae = 0; ws = 0; wc = 0; start = 0;
        if (!rst_n) begin
            m_prev_s <= 0; m_prev_c <= 0; m_ps <= 0; m_pc <= 0;
            w_v <= 0; free_at <= 0; m_walks <= 0; m_tmr <= 32'd0;
        end else begin
            se = regs_sa_snap && !m_prev_s;
            ce = regs_sa_clear_live && !m_prev_c;
`ifdef CR_CDDIP_SA_AUTO_SNAP_EN
            if (cfg_period_en && cfg_period != 0) begin
                if (m_tmr >= cfg_period - 1) begin
                    ae = 1;
                    m_tmr <= 32'd0;
                end else begin
                    m_tmr <= m_tmr + 32'd1;
                end
            end else begin
                m_tmr <= 32'd0;
            end
`endif
            m_prev_s <= regs_sa_snap;
            m_prev_c <= regs_sa_clear_live;
            if (e >= free_at) begin
                if (se || ae || m_ps) begin
                    start = 1; ws = 1;
                    wc = ce || m_pc || (se && regs_sa_clear_live);
                end else if (ce || m_pc) begin
                    start = 1; wc = 1;
                end
                if (start) begin
                    w_v <= 1; w_k <= e; w_s <= ws; w_c <= wc;
                    free_at <= e + (int'(ws) + int'(wc)) * N + 2;
                    m_ps <= 0;
                    if (wc) m_pc <= 0;
                end
            end else begin
                m_ps <= m_ps | se | ae;
                m_pc <= m_pc | ce;
            end
            if (w_v && w_s && e == w_k + (int'(w_s) + int'(w_c)) * N)
                m_walks <= m_walks + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        fork
            forever begin : compare
                logic e_ss, e_cs, e_busy, e_done;
                logic [5:0]  e_idx;
                logic [15:0] e_cnt;
                int off, wn, cb, tot;
                @(negedge clk);
                e_ss = 0; e_cs = 0; e_busy = 0; e_done = 0; e_idx = 6'd0; e_cnt = 16'd0;
                if (rst_n) begin
                    if (w_v && cyc >= w_k) begin
                        off = cyc - w_k;
                        wn  = (int'(w_s) + int'(w_c)) * N;
                        cb  = w_s ? N : 0;
                        if (w_s && off < N) begin
                            e_ss = 1; e_idx = 6'(off);
                        end else if (w_c && off >= cb && off < cb + N) begin
                            e_cs = 1; e_idx = 6'(off - cb);
                        end
                        if (off == wn) e_done = 1;
                        if (off <= wn) e_busy = 1;
                    end
                    tot = cnt_ofs + (m_walks - walk_mark);
                    e_cnt = (tot > 65535) ? 16'hFFFF : 16'(tot);
                end
                chk("cycle_outputs",
                    {6'd0, sa_snap_stb, sa_clear_stb, sa_idx, snap_busy, snap_done, snap_count},
                    {6'd0, e_ss, e_cs, e_idx, e_busy, e_done, e_cnt});
                chk("no_stb_overlap", {31'd0, sa_snap_stb & sa_clear_stb}, 32'd0);
            end
        join_none

        // reset state
        tick(2);
        chk("rst_busy", {31'd0, snap_busy}, 32'd0);
        chk("rst_count", {16'd0, snap_count}, 32'd0);
        rst_n = 1'b1;

        // single snap sampled at edge 10
        tick(7);
        regs_sa_snap = 1'b1;
        tick(1);
        chk("snap_start_cyc", cyc, 32'd10);
        chk("snap_start", {25'd0, sa_snap_stb, sa_idx}, {25'd0, 1'b1, 6'd0});
        regs_sa_snap = 1'b0;
        tick(63);
        chk("snap_last", {25'd0, sa_snap_stb, sa_idx}, {25'd0, 1'b1, 6'd63});
        tick(1);
        chk("snap_done_cyc", cyc, 32'd74);
        chk("snap_done", {14'd0, snap_done, sa_snap_stb, snap_count}, {14'd0, 1'b1, 1'b0, 16'd1});
        tick(1);
        chk("snap_idle", {25'd0, snap_busy, sa_idx}, 32'd0);

        // snap + clear together
        tick(3);
        regs_sa_snap = 1'b1;
        regs_sa_clear_live = 1'b1;
        tick(1);
        chk("both_start", {24'd0, sa_snap_stb, sa_clear_stb, sa_idx}, {24'd0, 2'b10, 6'd0});
        regs_sa_snap = 1'b0;
        regs_sa_clear_live = 1'b0;
        tick(64);
        chk("both_clear0", {24'd0, sa_snap_stb, sa_clear_stb, sa_idx}, {24'd0, 2'b01, 6'd0});
        tick(63);
        chk("both_clear63", {24'd0, sa_snap_stb, sa_clear_stb, sa_idx}, {24'd0, 2'b01, 6'd63});
        tick(1);
        chk("both_done", {15'd0, snap_done, snap_count}, {15'd0, 1'b1, 16'd2});
        tick(2);

        // clear edges during a snap walk merge into one pending clear walk
        regs_sa_snap = 1'b1;
        tick(1);
        regs_sa_snap = 1'b0;
        tick(4);
        repeat (4) begin
            regs_sa_clear_live = 1'b1;
            tick(1);
            regs_sa_clear_live = 1'b0;
            tick(1);
        end
        tick(52);
        chk("pend_done", {15'd0, snap_done, snap_count}, {15'd0, 1'b1, 16'd3});
        tick(1);
        chk("pend_idle", {31'd0, snap_busy}, 32'd0);
        tick(1);
        chk("pend_clear0", {24'd0, sa_snap_stb, sa_clear_stb, sa_idx}, {24'd0, 2'b01, 6'd0});
        tick(64);
        chk("pend_clear_done", {15'd0, snap_done, snap_count}, {15'd0, 1'b1, 16'd3});
        tick(5);
        chk("pend_single", {31'd0, snap_busy}, 32'd0);

        // reset mid-walk; snap held high across release restarts a walk
        regs_sa_snap = 1'b1;
        tick(1);
        regs_sa_snap = 1'b0;
        tick(30);
        chk("mid_idx", {26'd0, sa_idx}, 32'd30);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_outs", {6'd0, sa_snap_stb, sa_clear_stb, sa_idx, snap_busy, snap_done, snap_count}, 32'd0);
        regs_sa_snap = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("held_restart", {25'd0, sa_snap_stb, sa_idx}, {25'd0, 1'b1, 6'd0});
        regs_sa_snap = 1'b0;
        tick(64);
        chk("held_done", {15'd0, snap_done, snap_count}, {15'd0, 1'b1, 16'd1});
        tick(2);

        // saturation of snap_count
        force dut.snap_count = 16'hFFFE;
        walk_mark = m_walks;
        cnt_ofs = 65534;
        tick(1);
        release dut.snap_count;
        tick(1);
        chk("sat_preload", {16'd0, snap_count}, 32'h0000FFFE);
        regs_sa_snap = 1'b1;
        tick(1);
        regs_sa_snap = 1'b0;
        tick(64);
        chk("sat_reach", {16'd0, snap_count}, 32'h0000FFFF);
        tick(2);
        regs_sa_snap = 1'b1;
        tick(1);
        regs_sa_snap = 1'b0;
        tick(64);
        chk("sat_hold", {15'd0, snap_done, snap_count}, {15'd0, 1'b1, 16'hFFFF});
        tick(2);

        // auto-snap timer configuration
        cfg_period = 32'd200;
        cfg_period_en = 1'b1;
        tick(450);
`ifndef CR_CDDIP_SA_AUTO_SNAP_EN
        chk("no_auto_walk", {31'd0, snap_busy}, 32'd0);
`endif
        cfg_period = 32'd0;
        tick(300);
        cfg_period_en = 1'b0;
        tick(5);
        chk("final_idle", {31'd0, snap_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr_cddip_sa_snap_ctrl.md
CR_CDDIP_SA_SNAP_CTRL -- requirements
Module: cr_cddip_sa_snap_ctrl

Interface
REQ-001 SHALL have one parameter, N_ENTRIES, default 64: number of statistics entries walked per sequence.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port regs_sa_snap, input, 1 bit: software snapshot request level from the sa_global_ctrl register.
REQ-005 SHALL have port regs_sa_clear_live, input, 1 bit: software clear-live request level from the sa_global_ctrl register.
REQ-006 SHALL have port cfg_period, input, 32 bits: auto-snapshot period in clock cycles.
REQ-007 SHALL have port cfg_period_en, input, 1 bit: enables the auto-snapshot timer.
REQ-008 SHALL have port sa_snap_stb, output, 1 bit: copies live count[sa_idx] to snapshot[sa_idx].
REQ-009 SHALL have port sa_clear_stb, output, 1 bit: zeroes live count[sa_idx].
REQ-010 SHALL have port sa_idx, output, 6 bits: index of the entry being acted on.
REQ-011 SHALL have port snap_busy, output, 1 bit: high while the FSM is not IDLE.
REQ-012 SHALL have port snap_done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-013 SHALL have port snap_count, output, 16 bits: number of completed snapshot walks, saturating.

Function
REQ-014 SHALL register regs_sa_snap and regs_sa_clear_live into prev flops and detect a request as input & ~prev.
REQ-015 SHALL implement FSM states IDLE, SNAP, CLEAR and DONE; all outputs SHALL be driven from flops.
REQ-016 On a snap request in IDLE, the FSM SHALL enter SNAP at the next edge with sa_idx=0; it SHALL also latch do_clear = regs_sa_clear_live.
REQ-017 In SNAP, sa_snap_stb SHALL be 1 and sa_idx SHALL increment by one per cycle; after entry N_ENTRIES-1, the FSM SHALL go to CLEAR if do_clear=1, else to DONE.
REQ-018 A clear-only request in IDLE SHALL enter CLEAR with sa_idx=0. In CLEAR, sa_clear_stb SHALL be 1 for N_ENTRIES cycles, then the FSM SHALL go to DONE.
REQ-019 In DONE (one cycle), snap_done SHALL be 1; the FSM SHALL then return to IDLE. snap_count SHALL increment if the sequence included SNAP, saturating at 16'hFFFF.
REQ-020 Latency: with the request edge sampled at edge k, strobes SHALL be high for cycles k..k+N_ENTRIES-1 per walk, with DONE immediately after the last walk.
REQ-021 Simultaneous snap and clear edges SHALL produce SNAP followed by CLEAR.
REQ-022 A request arriving while busy SHALL set a one-deep pending flag per type; further requests of the same type SHALL merge.
REQ-023 Pending requests SHALL start from IDLE on the cycle after DONE, snap taking priority.
REQ-024 sa_snap_stb and sa_clear_stb SHALL never be high in the same cycle.
REQ-025 sa_idx SHALL be 0 whenever the FSM is IDLE or DONE.

Reset
REQ-026 rst_n low SHALL immediately force: FSM to IDLE; all outputs, sa_idx, snap_count, the prev flops, the pending flags, do_clear and the timer to 0.
REQ-027 Reset asserted mid-walk SHALL abort the walk with no DONE pulse.
REQ-028 An input held high across reset release SHALL be treated as a new request at the first sampling edge.

Configuration
REQ-029 With macro CR_CDDIP_SA_AUTO_SNAP_EN defined, a 32-bit timer SHALL count cycles while cfg_period_en=1 and cfg_period!=0.
REQ-030 On reaching cfg_period-1, the timer SHALL wrap to 0 and raise a snap-only request, with the same merge and pending rules as software requests.
REQ-031 Deasserting cfg_period_en SHALL reset the timer to 0.
REQ-032 Without CR_CDDIP_SA_AUTO_SNAP_EN, no timer SHALL exist; cfg_period and cfg_period_en SHALL be present but ignored.

Verification
REQ-033 Raise regs_sa_snap at edge 10 (clear_live=0) -> sa_snap_stb high cycles 10..73 with sa_idx 0..63; snap_done at cycle 74; snap_count=1.
REQ-034 Raise snap and clear_live together -> 64 snap strobes, then 64 clear strobes, one snap_done; stb overlap never observed.
REQ-035 Give a clear edge during a SNAP walk -> after DONE and one IDLE cycle, a 64-cycle CLEAR walk runs; three extra clear edges still yield only one walk.
REQ-036 Assert rst_n low at sa_idx=30 -> all outputs 0 at once; no snap_done; snap_count unchanged at 0.
REQ-037 With macro defined, cfg_period=200 and en=1 -> a snap walk starts every 200 cycles; cfg_period=0 -> no walks; without macro -> no auto walks.
REQ-038 Preload snap_count to 16'hFFFF via 65535 snaps, or force it -> a further snap leaves it at 16'hFFFF.
